// File: rtl/issue_queue_pkg.sv
// Shared widths, reset values and encodings for the issue queue slice.
package issue_queue_pkg;

    localparam int PC_BUS        = 32;
    localparam int DATA_BUS      = 32;
    localparam int REG_ADDR_BUS  = 5;
    localparam int DECODEOUT_BUS = 64;

    localparam logic [PC_BUS-1:0]   PC_INITIAL   = '0;
    localparam logic [DATA_BUS-1:0] DATA_INITIAL = '0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Number of instructions leaving the head in one cycle.
    typedef enum logic [1:0] {
        ISS_NONE = 2'd0,
        ISS_ONE  = 2'd1,
        ISS_TWO  = 2'd2
    } iss_cnt_e;

    // Register/memory fields the hazard checks look at.
    typedef struct packed {
        logic [REG_ADDR_BUS-1:0] rs;
        logic [REG_ADDR_BUS-1:0] rt;
        logic [REG_ADDR_BUS-1:0] rd;
        logic                    rfwe;
        logic                    ld;
        logic                    st;
    } hz_t;

    // What an occupied issue slot must remember for the load-use check.
    typedef struct packed {
        logic                    ld;
        logic                    rfwe;
        logic [REG_ADDR_BUS-1:0] rd;
    } slot_hz_t;

    // Lane 0 always holds the older instruction, so 10 never appears.
    function automatic logic [1:0] iss_valid_of(input iss_cnt_e c);
        case (c)
            ISS_TWO: return 2'b11;
            ISS_ONE: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode-side enqueue bus and lane-side issue slot outputs of the issue queue.
interface issue_queue_if #(
    parameter int DW = issue_queue_pkg::DECODEOUT_BUS
);
    import issue_queue_pkg::*;

    logic                    flush;
    logic                    stop;
    logic [1:0]              in_valid;
    logic                    in_ready;
    logic [PC_BUS-1:0]       in_pc0,   in_pc1;
    logic [DATA_BUS-1:0]     in_imm0,  in_imm1;
    logic [DW-1:0]           in_dec0,  in_dec1;
    logic [REG_ADDR_BUS-1:0] in_rs0,   in_rs1;
    logic [REG_ADDR_BUS-1:0] in_rt0,   in_rt1;
    logic [REG_ADDR_BUS-1:0] in_rd0,   in_rd1;
    logic                    in_rfwe0, in_rfwe1;
    logic                    in_ld0,   in_ld1;
    logic                    in_st0,   in_st1;
    logic [1:0]              iss_valid;
    logic [PC_BUS-1:0]       iss_pc0,  iss_pc1;
    logic [DATA_BUS-1:0]     iss_imm0, iss_imm1;
    logic [DW-1:0]           iss_dec0, iss_dec1;

    modport master (
        output flush, stop, in_valid,
        output in_pc0, in_pc1, in_imm0, in_imm1, in_dec0, in_dec1,
        output in_rs0, in_rs1, in_rt0, in_rt1, in_rd0, in_rd1,
        output in_rfwe0, in_rfwe1, in_ld0, in_ld1, in_st0, in_st1,
        input  in_ready, iss_valid,
        input  iss_pc0, iss_pc1, iss_imm0, iss_imm1, iss_dec0, iss_dec1
    );

    modport slave (
        input  flush, stop, in_valid,
        input  in_pc0, in_pc1, in_imm0, in_imm1, in_dec0, in_dec1,
        input  in_rs0, in_rs1, in_rt0, in_rt1, in_rd0, in_rd1,
        input  in_rfwe0, in_rfwe1, in_ld0, in_ld1, in_st0, in_st1,
        output in_ready, iss_valid,
        output iss_pc0, iss_pc1, iss_imm0, iss_imm1, iss_dec0, iss_dec1
    );

endinterface

// File: rtl/issue_queue_iq_hazard.sv
// iq_hazard: decides how many head instructions may issue this cycle.
module iq_hazard
    import issue_queue_pkg::*;
(
    input  hz_t        h0,
    input  hz_t        h1,
    input  logic       h0_present,
    input  logic       h1_present,
    input  logic [1:0] slot_valid,
    input  slot_hz_t   slot0,
    input  slot_hz_t   slot1,
    output iss_cnt_e   cnt
);

    // A load still in stage 1 cannot forward to a consumer issued right behind it.
    function automatic logic load_use(input slot_hz_t s, input logic v, input hz_t h);
        return v && s.ld && s.rfwe && (s.rd != '0) && ((s.rd == h.rs) || (s.rd == h.rt));
    endfunction

    logic lu0, lu1, raw, waw, two_mem, issue0, issue1;

    // Combine head presence, stage-1 load-use and intra-pair ordering into a count.
    always_comb begin
        lu0     = load_use(slot0, slot_valid[0], h0) || load_use(slot1, slot_valid[1], h0);
        lu1     = load_use(slot0, slot_valid[0], h1) || load_use(slot1, slot_valid[1], h1);
        raw     = h0.rfwe && (h0.rd != '0) && ((h0.rd == h1.rs) || (h0.rd == h1.rt));
        waw     = h0.rfwe && h1.rfwe && (h0.rd != '0) && (h0.rd == h1.rd);
        two_mem = (h0.ld || h0.st) && (h1.ld || h1.st);
        issue0  = h0_present && !lu0;
        issue1  = issue0 && h1_present && !lu1 && !raw && !waw && !two_mem;
        cnt     = ISS_NONE;
        if (issue1) begin
            cnt = ISS_TWO;
        end else if (issue0) begin
            cnt = ISS_ONE;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order dual-issue buffer feeding the registered issue slot pair.
// Optional build macro ISSUE_BYPASS_EN: when the queue is empty, incoming
// instructions that pass the hazard rules go straight into the issue slots.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = DECODEOUT_BUS
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [PC_BUS-1:0]   pc_mem  [DEPTH];
    logic [DATA_BUS-1:0] imm_mem [DEPTH];
    logic [DW-1:0]       dec_mem [DEPTH];
    hz_t                 hz_mem  [DEPTH];

    logic [PC_BUS-1:0]   in_pc  [2];
    logic [DATA_BUS-1:0] in_imm [2];
    logic [DW-1:0]       in_dec [2];
    hz_t                 in_hz  [2];

    logic [PC_BUS-1:0]   h_pc  [2];
    logic [DATA_BUS-1:0] h_imm [2];
    logic [DW-1:0]       h_dec [2];
    hz_t                 h_hz  [2];
    logic [1:0]          h_present;

    ptr_t                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count, count_next;
    logic                in_ready_q, in_ready_d;
    logic [1:0]          iss_valid_q, iss_valid_d;
    logic [PC_BUS-1:0]   iss_pc_q  [2], iss_pc_d  [2];
    logic [DATA_BUS-1:0] iss_imm_q [2], iss_imm_d [2];
    logic [DW-1:0]       iss_dec_q [2], iss_dec_d [2];
    slot_hz_t            slot_hz_q [2], slot_hz_d [2];

    logic                enq, empty;
    logic [1:0]          n_enq, n_iss;
    logic [AW-1:0]       wa0, wa1, ra0, ra1;
    iss_cnt_e            iss_cnt;

    assign in_pc[0]  = bus.in_pc0;
    assign in_pc[1]  = bus.in_pc1;
    assign in_imm[0] = bus.in_imm0;
    assign in_imm[1] = bus.in_imm1;
    assign in_dec[0] = bus.in_dec0;
    assign in_dec[1] = bus.in_dec1;
    assign in_hz[0]  = '{rs: bus.in_rs0, rt: bus.in_rt0, rd: bus.in_rd0,
                         rfwe: bus.in_rfwe0, ld: bus.in_ld0, st: bus.in_st0};
    assign in_hz[1]  = '{rs: bus.in_rs1, rt: bus.in_rt1, rd: bus.in_rd1,
                         rfwe: bus.in_rfwe1, ld: bus.in_ld1, st: bus.in_st1};

    // A lone slot-1 valid (10) is not a legal enqueue and is dropped.
    assign enq   = in_ready_q && bus.in_valid[0];
    assign n_enq = enq ? (bus.in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign wa0   = wr_ptr_q[AW-1:0];
    assign wa1   = wa0 + AW'(1);
    assign ra0   = rd_ptr_q[AW-1:0];
    assign ra1   = ra0 + AW'(1);

    // Storage array: write accepted instructions at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && enq) begin
            pc_mem[wa0]  <= in_pc[0];
            imm_mem[wa0] <= in_imm[0];
            dec_mem[wa0] <= in_dec[0];
            hz_mem[wa0]  <= in_hz[0];
            if (bus.in_valid[1]) begin
                pc_mem[wa1]  <= in_pc[1];
                imm_mem[wa1] <= in_imm[1];
                dec_mem[wa1] <= in_dec[1];
                hz_mem[wa1]  <= in_hz[1];
            end
        end
    end

    // Present the two oldest instructions (or, with bypass, the incoming pair) as issue candidates.
    always_comb begin
        h_pc[0]      = pc_mem[ra0];
        h_pc[1]      = pc_mem[ra1];
        h_imm[0]     = imm_mem[ra0];
        h_imm[1]     = imm_mem[ra1];
        h_dec[0]     = dec_mem[ra0];
        h_dec[1]     = dec_mem[ra1];
        h_hz[0]      = hz_mem[ra0];
        h_hz[1]      = hz_mem[ra1];
        h_present[0] = !empty;
        h_present[1] = (count >= ptr_t'(2));
`ifdef ISSUE_BYPASS_EN
        // Entries are still written to storage; rd_ptr simply skips those that issue.
        if (empty) begin
            h_pc         = in_pc;
            h_imm        = in_imm;
            h_dec        = in_dec;
            h_hz         = in_hz;
            h_present[0] = enq;
            h_present[1] = enq && bus.in_valid[1];
        end
`endif
    end

    iq_hazard u_hazard (
        .h0         (h_hz[0]),
        .h1         (h_hz[1]),
        .h0_present (h_present[0]),
        .h1_present (h_present[1]),
        .slot_valid (iss_valid_q),
        .slot0      (slot_hz_q[0]),
        .slot1      (slot_hz_q[1]),
        .cnt        (iss_cnt)
    );

    assign n_iss = iss_cnt;

    // Next pointers, issue slots and ready; flush wins over stop and enqueue.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        iss_valid_d = iss_valid_q;
        iss_pc_d    = iss_pc_q;
        iss_imm_d   = iss_imm_q;
        iss_dec_d   = iss_dec_q;
        slot_hz_d   = slot_hz_q;
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            iss_valid_d = 2'b00;
        end else begin
            wr_ptr_d = wr_ptr_q + ptr_t'(n_enq);
            if (!bus.stop) begin
                rd_ptr_d    = rd_ptr_q + ptr_t'(n_iss);
                iss_valid_d = iss_valid_of(iss_cnt);
                for (int i = 0; i < 2; i++) begin
                    iss_pc_d[i]  = h_pc[i];
                    iss_imm_d[i] = h_imm[i];
                    iss_dec_d[i] = h_dec[i];
                    slot_hz_d[i] = '{ld: h_hz[i].ld, rfwe: h_hz[i].rfwe, rd: h_hz[i].rd};
                end
            end
        end
        // Ready is registered: requiring two free entries means an accepted pair never overflows.
        count_next = wr_ptr_d - rd_ptr_d;
        in_ready_d = (count_next <= ptr_t'(DEPTH - 2)) ? ENABLE : DISABLE;
    end

    // Control and issue slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= ENABLE;
            iss_valid_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                iss_pc_q[i]  <= PC_INITIAL;
                iss_imm_q[i] <= DATA_INITIAL;
                iss_dec_q[i] <= '0;
                slot_hz_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            iss_valid_q <= iss_valid_d;
            iss_pc_q    <= iss_pc_d;
            iss_imm_q   <= iss_imm_d;
            iss_dec_q   <= iss_dec_d;
            slot_hz_q   <= slot_hz_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.iss_valid = iss_valid_q;
    assign bus.iss_pc0   = iss_pc_q[0];
    assign bus.iss_pc1   = iss_pc_q[1];
    assign bus.iss_imm0  = iss_imm_q[0];
    assign bus.iss_imm1  = iss_imm_q[1];
    assign bus.iss_dec0  = iss_dec_q[0];
    assign bus.iss_dec1  = iss_dec_q[1];

endmodule
